ffn_bias_relu_requant: RTL and testbench

- Feed-forward post-processing stage directly downstream of matrix_multiply.
- Consumes the N x Dout signed 2*WIDTH product matrix and adds a per-column bias.
- Applies ReLU, then requantizes with a round-half-up arithmetic right shift and saturation back to WIDTH bits, so the result can feed the next layer's matrix_multiply `a` operand.
- Uses the same START/DONE handshake as matrix_multiply and processes one element per clock through a 2-stage pipeline.

---
 rtl/ffn_bias_relu_requant.sv | 153 +++++++++++++++
 tb/tb_ffn_bias_relu_requant.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ffn_bias_relu_requant.sv
`default_nettype none
// ============================================================================
// Module  : ffn_bias_relu_requant
// Purpose : Per-column bias add, ReLU and round-half-up requantization of a
//           2*WIDTH product matrix, one element per clock, 2-stage pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module ffn_bias_relu_requant #(
    parameter int N     = 3,
    parameter int Dout  = 3,
    parameter int WIDTH = 8,
    parameter int SHIFT = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        START,
    input  logic signed [N-1:0][Dout-1:0][2*WIDTH-1:0]  c,
    input  logic signed [Dout-1:0][2*WIDTH-1:0]         bias,
    output logic signed [N-1:0][Dout-1:0][WIDTH-1:0]    y,
    output logic                                        DONE
);

    localparam int c_RW   = (N > 1)    ? $clog2(N)    : 1;
    localparam int c_CW   = (Dout > 1) ? $clog2(Dout) : 1;
    localparam int c_SW   = 2*WIDTH + 1;
    localparam int c_TW   = 2*WIDTH + 2;
    // (1 << SHIFT) >> 1 yields 2^(SHIFT-1), and 0 when SHIFT is 0
    localparam logic [c_TW-1:0] c_RND = (c_TW'(1) << SHIFT) >> 1;
    localparam logic [c_TW-1:0] c_MAX = c_TW'((1 << (WIDTH-1)) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                               state_q, state_d;
    logic [c_RW-1:0]                      row_q, row_d;
    logic [c_CW-1:0]                      col_q, col_d;
    logic                                 vld_q, vld_d;
    logic signed [c_SW-1:0]               sum_q, sum_d;
    logic [c_RW-1:0]                      srow_q, srow_d;
    logic [c_CW-1:0]                      scol_q, scol_d;
    logic [N-1:0][Dout-1:0][WIDTH-1:0]    y_q, y_d;
    logic                                 done_q, done_d;

    logic                                 w_col_end;
    logic                                 w_last;
    logic [c_TW-1:0]                      w_t;
    logic [WIDTH-1:0]                     w_res;

    assign w_col_end = (col_q == c_CW'(Dout-1));
    assign w_last    = w_col_end && (row_q == c_RW'(N-1));

    // Sum is only rounded/shifted when positive, so the sign-extended
    // widening never feeds a negative value into the shift.
    assign w_t = (c_TW'(sum_q) + c_RND) >> SHIFT;

    always_comb begin
        w_res = '0;
        if (sum_q > 0) begin
            if (w_t > c_MAX) begin
                w_res = c_MAX[WIDTH-1:0];
            end else begin
                w_res = w_t[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        vld_d   = 1'b0;
        sum_d   = sum_q;
        srow_d  = srow_q;
        scol_d  = scol_q;
        y_d     = y_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                vld_d  = 1'b1;
                sum_d  = c_SW'($signed(c[row_q][col_q])) + c_SW'($signed(bias[col_q]));
                srow_d = row_q;
                scol_d = col_q;
                if (w_col_end) begin
                    col_d = '0;
                    row_d = w_last ? '0 : row_q + c_RW'(1);
                end else begin
                    col_d = col_q + c_CW'(1);
                end
                if (w_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                if (START) begin
                    state_d = S_RUN;
                    done_d  = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (vld_q) begin
            y_d[srow_q][scol_q] = w_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            vld_q   <= 1'b0;
            sum_q   <= '0;
            srow_q  <= '0;
            scol_q  <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vld_q   <= vld_d;
            sum_q   <= sum_d;
            srow_q  <= srow_d;
            scol_q  <= scol_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ffn_bias_relu_requant.sv
`default_nettype none
// ============================================================================
// Module  : tb_ffn_bias_relu_requant
// Purpose : Scoreboard bench for ffn_bias_relu_requant (3x3, SHIFT=0, 1x4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ffn_bias_relu_requant;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ey [9];
        int n;
        int done_edge;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // DUT0: 3x3, SHIFT=2
    logic                      start0;
    logic [2:0][2:0][15:0]     c0;
    logic [2:0][15:0]          bias0;
    logic [2:0][2:0][7:0]      y0;
    logic                      done0;

    // DUT1: 1x2, SHIFT=0
    logic                      start1;
    logic [0:0][1:0][15:0]     c1;
    logic [1:0][15:0]          bias1;
    logic [0:0][1:0][7:0]      y1;
    logic                      done1;

    // DUT2: 1x4, SHIFT=1
    logic                      start2;
    logic [0:0][3:0][15:0]     c2;
    logic [3:0][15:0]          bias2;
    logic [0:0][3:0][7:0]      y2;
    logic                      done2;

    ffn_bias_relu_requant #(.N(3), .Dout(3), .WIDTH(8), .SHIFT(2)) u_dut0 (
        .clk(clk), .reset(reset), .START(start0), .c(c0), .bias(bias0), .y(y0), .DONE(done0)
    );
    ffn_bias_relu_requant #(.N(1), .Dout(2), .WIDTH(8), .SHIFT(0)) u_dut1 (
        .clk(clk), .reset(reset), .START(start1), .c(c1), .bias(bias1), .y(y1), .DONE(done1)
    );
    ffn_bias_relu_requant #(.N(1), .Dout(4), .WIDTH(8), .SHIFT(1)) u_dut2 (
        .clk(clk), .reset(reset), .START(start2), .c(c2), .bias(bias2), .y(y2), .DONE(done2)
    );

    // Hand-computed vectors (row-major)
    int T1C [9] = '{-30, 36, -42, 66, -81, 96, -102, 126, -150};
    int T1B [3] = '{0, 4, -2};
    int T1E [9] = '{0, 10, 0, 17, 0, 24, 0, 33, 0};
    int AC  [9] = '{5, 6, 1, 0, -1, 1000, 4, 2, 3};
    int AB  [3] = '{0, 0, 0};
    int AE  [9] = '{1, 2, 0, 0, 0, 127, 1, 1, 1};
    int BC  [9] = '{32767, -32768, 0, 0, 0, 9, -32768, 32767, -9};
    int BB  [3] = '{32767, -32768, 0};
    int BE  [9] = '{127, 0, 0, 127, 0, 2, 0, 0, 0};

    task automatic check(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_result(input string nm, input int got [9], input int edge_now, input exp_t e);
        check({nm, " done_edge"}, edge_now, e.done_edge);
        for (int i = 0; i < e.n; i++) begin
            check($sformatf("%s y[%0d]", nm, i), got[i], e.ey[i]);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s DONE rose with empty scoreboard got 1 want 0", nm);
    endtask

    // Monitors: compare on each DONE rising edge
    logic d0p = 1'b0, d1p = 1'b0, d2p = 1'b0;

    always @(negedge clk) begin
        int   g [9];
        exp_t e;
        if (done0 && !d0p) begin
            if (q0.size() == 0) unexpected("dut0");
            else begin
                e = q0.pop_front();
                for (int i = 0; i < 9; i++) g[i] = int'(y0[i/3][i%3]);
                check_result("dut0", g, edge_cnt, e);
            end
        end
        d0p = done0;
    end

    always @(negedge clk) begin
        int   g [9];
        exp_t e;
        if (done1 && !d1p) begin
            if (q1.size() == 0) unexpected("dut1");
            else begin
                e = q1.pop_front();
                for (int i = 0; i < 9; i++) g[i] = (i < 2) ? int'(y1[0][i]) : 0;
                check_result("dut1", g, edge_cnt, e);
            end
        end
        d1p = done1;
    end

    always @(negedge clk) begin
        int   g [9];
        exp_t e;
        if (done2 && !d2p) begin
            if (q2.size() == 0) unexpected("dut2");
            else begin
                e = q2.pop_front();
                for (int i = 0; i < 9; i++) g[i] = (i < 4) ? int'(y2[0][i]) : 0;
                check_result("dut2", g, edge_cnt, e);
            end
        end
        d2p = done2;
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic wait_q(input int which);
        for (int k = 0; k < 40 && qsize(which) != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (qsize(which) != 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d timeout pending %0d want 0", which, qsize(which));
            case (which)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    task automatic run0(input int cv [9], input int bv [3], input int ev [9], input bit push);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 9; i++) c0[i/3][i%3] = 16'(cv[i]);
        for (int k = 0; k < 3; k++) bias0[k] = 16'(bv[k]);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        if (push) begin
            e.ey        = ev;
            e.n         = 9;
            e.done_edge = edge_cnt + 10;
            q0.push_back(e);
        end
        check("dut0 DONE after START edge", int'(done0), 0);
    endtask

    initial begin
        exp_t e;
        reset  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        c0 = '0; bias0 = '0; c1 = '0; bias1 = '0; c2 = '0; bias2 = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) check($sformatf("reset y[%0d]", i), int'(y0[i/3][i%3]), 0);
        check("reset DONE", int'(done0), 0);
        @(negedge clk);
        reset = 1'b1;

        // Nominal, rounding/ReLU, saturation
        run0(T1C, T1B, T1E, 1'b1); wait_q(0);
        run0(AC,  AB,  AE,  1'b1); wait_q(0);
        run0(BC,  BB,  BE,  1'b1); wait_q(0);

        // START pulses at edges 3 and 5 of a run must be ignored
        run0(T1C, T1B, T1E, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        @(negedge clk); start0 = 1'b0;
        @(posedge clk);
        @(negedge clk); start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_q(0);

        // Restart from the done state with new data
        run0(AC, AB, AE, 1'b1); wait_q(0);

        // Asynchronous reset between edges 4 and 5 of a run
        run0(T1C, T1B, T1E, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) check($sformatf("midreset y[%0d]", i), int'(y0[i/3][i%3]), 0);
        check("midreset DONE", int'(done0), 0);
        @(negedge clk);
        reset = 1'b1;
        run0(T1C, T1B, T1E, 1'b1); wait_q(0);

        // SHIFT=0: pass-through with saturation
        @(negedge clk);
        c1[0][0] = 16'd127; c1[0][1] = 16'd128; bias1 = '0;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        e.ey = '{127, 127, 0, 0, 0, 0, 0, 0, 0};
        e.n = 2;
        e.done_edge = edge_cnt + 3;
        q1.push_back(e);
        wait_q(1);

        // Degenerate 1x4, SHIFT=1
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            c2[0][k]  = 16'd4;
            bias2[k]  = 16'(k + 1);
        end
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        e.ey = '{3, 3, 4, 4, 0, 0, 0, 0, 0};
        e.n = 4;
        e.done_edge = edge_cnt + 5;
        q2.push_back(e);
        wait_q(2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
